output_arbiter: RTL and testbench
=================================

OUTPUT_ARBITER -- requirements
Module: output_arbiter

Interface
REQ-001 Parameter: BUF_DEPTH, 4, downstream input-buffer depth in flits (initial credits); legal range 1..15.
REQ-002 Parameter: OWN_PORT, 0, index of the port this arbiter drives; req[OWN_PORT] is ignored (no U-turn).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req  input  5  per-input-port request for this output; bit order 0=L, 1=N, 2=S, 3=E, 4=W.
REQ-006 tail  input  5  per-input-port flag: the flit currently presented is the packet tail; qualified only by req.
REQ-007 credit_in  input  1  one-cycle pulse, one downstream buffer slot freed.
REQ-008 grant  output  5  registered, one-hot or zero; the current packet owner.
REQ-009 sel  output  3  registered crossbar select: 0..4 = owner index, 7 = none.
REQ-010 send  output  1  combinational; a flit crosses to this output this cycle.
REQ-011 credit_cnt  output  4  registered count of available downstream slots.
REQ-012 credit_err  output  1  registered, sticky; credit overflow detected.

Function
REQ-013 FSM states IDLE and ACTIVE; the owner index and round-robin pointer ptr (0..4) are registered.
REQ-014 IDLE: eff_req = req with bit OWN_PORT cleared; if eff_req != 0, the winner is the first set bit searching ptr, ptr+1, ... mod 5.
REQ-015 IDLE with winner: next edge loads grant = onehot(winner), sel = winner, state = ACTIVE; no flit is sent in the arbitration cycle (1-cycle arbitration latency).
REQ-016 Arbitration does not depend on credit_cnt; a packet may be granted with 0 credits and stalls in ACTIVE.
REQ-017 ACTIVE: send = req[owner] AND credit_cnt != 0; send is 0 in IDLE.
REQ-018 ACTIVE: grant holds for the whole packet (wormhole); deassertion of req[owner] without tail does not release the grant.
REQ-019 ACTIVE with send AND tail[owner]: next edge sets grant = 0, sel = 7, state = IDLE, ptr = (owner+1) mod 5.
REQ-020 Tail-release and a new arbitration never coincide; the earliest re-grant is edge n+2 after a tail sent at cycle n, so each packet change costs one bubble cycle.
REQ-021 Other requesters' req/tail changes in ACTIVE have no effect.
REQ-022 credit_cnt next = credit_cnt + credit_in - send; simultaneous credit_in and send leaves it unchanged.
REQ-023 credit_in with credit_cnt == BUF_DEPTH and no send: count holds at BUF_DEPTH and credit_err is set.
REQ-024 send never occurs with credit_cnt == 0, so credit_cnt never underflows.
REQ-025 Single-flit packets (head is tail): grant, send with tail, then release, following REQ-015 and REQ-019.

Reset
REQ-026 rst_n low at a rising edge sets state = IDLE, grant = 0, sel = 7, ptr = 0, credit_cnt = BUF_DEPTH, credit_err = 0; send is 0 while state is IDLE.
REQ-027 Reset mid-packet aborts the packet: the owner is lost, credits return to BUF_DEPTH, and there is no residual send.
REQ-028 The first edge with rst_n high performs normal IDLE arbitration.

Verification
REQ-029 Round-robin: after reset, hold req = 5'b11110 with OWN_PORT = 0, and every flit a tail with credits kept at 4 -> grant sequence N, S, E, W, N... Each grant lasts 1 cycle, followed by a 1-cycle bubble.
REQ-030 Credit stall: a 6-flit packet from E with BUF_DEPTH = 4 and no credit_in -> send pulses 4 times and credit_cnt goes 4, 3, 2, 1, 0. Then send stays 0 and grant stays E. One credit_in pulse gives exactly one more send.
REQ-031 Simultaneous events: credit_cnt = 2, with send and credit_in in the same cycle -> credit_cnt stays 2. A credit_in at credit_cnt = 4 with no send -> credit_cnt stays 4 and credit_err = 1 and stays 1.
REQ-032 Wormhole hold: owner S drops req for 3 cycles mid-packet while N and W request -> grant stays S and send = 0 for 3 cycles. The packet then resumes, and after the S tail the next grant is W (ptr = 3, searching E then W).
REQ-033 Self-port mask: with OWN_PORT = 2, req = 5'b00100 only -> grant stays 0 and send stays 0 indefinitely.
REQ-034 Reset mid-packet: rst_n low for 1 cycle while L owns the output with credit_cnt = 1 -> next cycle grant = 0, sel = 7, credit_cnt = 4, ptr = 0. A pending req = 5'b00010 is then granted to N on the first edge after rst_n rises.

Source files
------------

// File: rtl/output_arbiter.sv
// Wormhole output arbiter: round-robin packet grant over five input ports with
// downstream credit tracking. A grant holds until the owner's tail flit is sent.
module output_arbiter #(
    parameter int unsigned BUF_DEPTH = 4,
    parameter int unsigned OWN_PORT  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] req,
    input  logic [4:0] tail,
    input  logic       credit_in,
    output logic [4:0] grant,
    output logic [2:0] sel,
    output logic       send,
    output logic [3:0] credit_cnt,
    output logic       credit_err
);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    localparam logic [3:0] Depth   = 4'(BUF_DEPTH);
    localparam logic [4:0] OwnMask = 5'(1 << OWN_PORT);
    localparam logic [2:0] SelNone = 3'd7;

    state_e     state_q, state_d;
    logic [4:0] grant_q, grant_d;
    logic [2:0] sel_q, sel_d;
    logic [2:0] ptr_q, ptr_d;
    logic [3:0] credit_q, credit_d;
    logic       err_q, err_d;

    logic [4:0] eff_req;
    logic       found;
    logic [2:0] winner;
    logic [2:0] idx;
    logic       owner_tail;

    // Round-robin search starting at ptr_q, wrapping modulo 5.
    always_comb begin
        eff_req = req & ~OwnMask;
        found   = 1'b0;
        winner  = 3'd0;
        idx     = ptr_q;
        for (int i = 0; i < 5; i++) begin
            if (!found && eff_req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
            idx = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
        end
    end

    // grant_q is one-hot on the owner, so masking with it selects the owner's bits.
    assign send       = (state_q == StActive) && (|(req & grant_q)) && (credit_q != 4'd0);
    assign owner_tail = |(tail & grant_q);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StActive;
                    grant_d = 5'b00001 << winner;
                    sel_d   = winner;
                end
            end
            StActive: begin
                if (send && owner_tail) begin
                    state_d = StIdle;
                    grant_d = 5'd0;
                    sel_d   = SelNone;
                    ptr_d   = (sel_q == 3'd4) ? 3'd0 : sel_q + 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        credit_d = credit_q;
        err_d    = err_q;
        if (credit_in && !send && credit_q == Depth) begin
            err_d = 1'b1;
        end else begin
            credit_d = credit_q + {3'b000, credit_in} - {3'b000, send};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            grant_q  <= 5'd0;
            sel_q    <= SelNone;
            ptr_q    <= 3'd0;
            credit_q <= Depth;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            sel_q    <= sel_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
            err_q    <= err_d;
        end
    end

    assign grant      = grant_q;
    assign sel        = sel_q;
    assign credit_cnt = credit_q;
    assign credit_err = err_q;

endmodule

// File: tb/tb_output_arbiter.sv
// Self-checking bench for output_arbiter: vector table, directed corner sequences
// and randomized traffic against a packet-level reference model.
module tb_output_arbiter;

    localparam int Buf = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] req = '0;
    logic [4:0] tail = '0;
    logic       credit_in = 1'b0;

    logic [4:0] grant, grant2;
    logic [2:0] sel, sel2;
    logic       send, send2;
    logic [3:0] credit_cnt, credit_cnt2;
    logic       credit_err, credit_err2;

    int errors = 0;
    int checks = 0;

    // Reference model state: owner index (-1 = none), round-robin pointer, credits.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cred  = Buf;
    bit m_err   = 1'b0;
    bit m_send  = 1'b0;
    bit armed   = 1'b0;

    output_arbiter #(.BUF_DEPTH(Buf), .OWN_PORT(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .tail(tail), .credit_in(credit_in),
        .grant(grant), .sel(sel), .send(send), .credit_cnt(credit_cnt),
        .credit_err(credit_err)
    );

    output_arbiter #(.BUF_DEPTH(Buf), .OWN_PORT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req(req), .tail(tail), .credit_in(credit_in),
        .grant(grant2), .sel(sel2), .send(send2), .credit_cnt(credit_cnt2),
        .credit_err(credit_err2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs, compare the main DUT against the model, advance the model.
    task automatic step(input logic [4:0] r, input logic [4:0] t, input logic c,
                        input logic rn);
        logic [4:0] eg;
        logic [2:0] es;
        logic [4:0] sh;
        logic [4:0] eff;
        int         nxt;
        @(negedge clk);
        req = r; tail = t; credit_in = c; rst_n = rn;
        #1;
        eg = (m_owner < 0) ? 5'd0 : 5'(1 << m_owner);
        es = (m_owner < 0) ? 3'd7 : 3'(m_owner);
        m_send = 1'b0;
        if (m_owner >= 0) begin
            sh = r >> m_owner;
            m_send = sh[0] && (m_cred > 0);
        end
        if (armed)
            chk("model", {grant, sel, send, credit_cnt, credit_err},
                {eg, es, m_send, 4'(m_cred), m_err});
        if (!rn) begin
            m_owner = -1; m_ptr = 0; m_cred = Buf; m_err = 1'b0;
        end else begin
            if (m_owner < 0) begin
                eff = r & 5'b11110;
                nxt = -1;
                for (int k = 0; k < 5; k++) begin
                    sh = eff >> ((m_ptr + k) % 5);
                    if (nxt < 0 && sh[0]) nxt = (m_ptr + k) % 5;
                end
                m_owner = nxt;
            end else begin
                sh = t >> m_owner;
                if (m_send && sh[0]) begin
                    m_ptr = (m_owner + 1) % 5;
                    m_owner = -1;
                end
            end
            if (c && !m_send && m_cred == Buf) m_err = 1'b1;
            else m_cred = m_cred + int'(c) - int'(m_send);
        end
    endtask

    task automatic do_reset();
        step(5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic [4:0] req;
        logic [4:0] tail;
        logic       cin;
        logic [4:0] grant;
        logic [2:0] sel;
        logic       send;
        logic [3:0] cnt;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int sends;
        int flits;
        logic [4:0] tl;

        // Round-robin over N,S,E,W with single-flit packets; credit returned on each send.
        vecs[0] = '{5'b11110, 5'b11111, 1'b0, 5'b00000, 3'd7, 1'b0, 4'd4};
        vecs[1] = '{5'b11110, 5'b11111, 1'b1, 5'b00010, 3'd1, 1'b1, 4'd4};
        vecs[2] = '{5'b11110, 5'b11111, 1'b0, 5'b00000, 3'd7, 1'b0, 4'd4};
        vecs[3] = '{5'b11110, 5'b11111, 1'b1, 5'b00100, 3'd2, 1'b1, 4'd4};
        vecs[4] = '{5'b11110, 5'b11111, 1'b0, 5'b00000, 3'd7, 1'b0, 4'd4};
        vecs[5] = '{5'b11110, 5'b11111, 1'b1, 5'b01000, 3'd3, 1'b1, 4'd4};
        vecs[6] = '{5'b11110, 5'b11111, 1'b0, 5'b00000, 3'd7, 1'b0, 4'd4};
        vecs[7] = '{5'b11110, 5'b11111, 1'b1, 5'b10000, 3'd4, 1'b1, 4'd4};
        vecs[8] = '{5'b11110, 5'b11111, 1'b0, 5'b00000, 3'd7, 1'b0, 4'd4};
        vecs[9] = '{5'b11110, 5'b11111, 1'b1, 5'b00010, 3'd1, 1'b1, 4'd4};

        do_reset();
        armed = 1'b1;
        do_reset();
        chk("reset_state", {grant, sel, send, credit_cnt, credit_err},
            {5'd0, 3'd7, 1'b0, 4'd4, 1'b0});

        foreach (vecs[i]) begin
            step(vecs[i].req, vecs[i].tail, vecs[i].cin, 1'b1);
            chk($sformatf("rr_vec%0d", i), {grant, sel, send, credit_cnt},
                {vecs[i].grant, vecs[i].sel, vecs[i].send, vecs[i].cnt});
        end

        // Credit stall: six-flit packet from E with no returned credits.
        do_reset();
        step(5'b01000, 5'd0, 1'b0, 1'b1);
        sends = 0; flits = 0;
        for (int i = 0; i < 8; i++) begin
            tl = (flits == 5) ? 5'b01000 : 5'd0;
            step(5'b01000, tl, 1'b0, 1'b1);
            if (send) sends++;
            if (m_send) flits++;
        end
        chk("stall_sends", 32'(sends), 32'd4);
        chk("stall_hold", {grant, send, credit_cnt}, {5'b01000, 1'b0, 4'd0});
        sends = 0;
        for (int i = 0; i < 4; i++) begin
            step(5'b01000, 5'd0, (i == 0), 1'b1);
            if (send) sends++;
            if (m_send) flits++;
        end
        chk("stall_one_credit", 32'(sends), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tl = (flits == 5) ? 5'b01000 : 5'd0;
            step(5'b01000, tl, 1'b1, 1'b1);
            if (m_send) flits++;
        end

        // Simultaneous send and credit, then overflow at full credit.
        do_reset();
        step(5'b00010, 5'd0, 1'b0, 1'b1);
        step(5'b00010, 5'd0, 1'b0, 1'b1);
        step(5'b00010, 5'd0, 1'b0, 1'b1);
        step(5'b00010, 5'd0, 1'b1, 1'b1);
        step(5'b00000, 5'd0, 1'b1, 1'b1);
        chk("simul_cnt", 32'(credit_cnt), 32'd2);
        step(5'b00000, 5'd0, 1'b1, 1'b1);
        step(5'b00000, 5'd0, 1'b1, 1'b1);
        step(5'b00000, 5'd0, 1'b0, 1'b1);
        chk("overflow", {credit_cnt, credit_err}, {4'd4, 1'b1});
        step(5'b00000, 5'd0, 1'b0, 1'b1);
        step(5'b00000, 5'd0, 1'b0, 1'b1);
        chk("err_sticky", 32'(credit_err), 32'd1);

        // Wormhole hold: S drops req mid-packet while N and W request.
        do_reset();
        step(5'b00100, 5'd0, 1'b0, 1'b1);
        step(5'b00100, 5'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(5'b10010, 5'd0, 1'b0, 1'b1);
            chk($sformatf("worm_hold%0d", i), {grant, send}, {5'b00100, 1'b0});
        end
        step(5'b10110, 5'b00100, 1'b0, 1'b1);
        chk("worm_tail_send", 32'(send), 32'd1);
        step(5'b10010, 5'd0, 1'b0, 1'b1);
        chk("worm_bubble", 32'(grant), 32'd0);
        step(5'b10010, 5'd0, 1'b0, 1'b1);
        chk("worm_next_w", {grant, sel}, {5'b10000, 3'd4});

        // Own-port mask on the OWN_PORT=2 instance.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(5'b00100, 5'b00100, 1'b0, 1'b1);
            chk($sformatf("self_mask%0d", i), {grant2, send2}, {5'd0, 1'b0});
        end

        // Reset mid-packet on the OWN_PORT=2 instance with L as owner.
        do_reset();
        for (int i = 0; i < 4; i++) step(5'b00001, 5'd0, 1'b0, 1'b1);
        step(5'b00010, 5'd0, 1'b0, 1'b0);
        chk("midrst_pre", {grant2, credit_cnt2}, {5'b00001, 4'd1});
        step(5'b00010, 5'd0, 1'b0, 1'b1);
        chk("midrst_post", {grant2, sel2, send2, credit_cnt2, credit_err2},
            {5'd0, 3'd7, 1'b0, 4'd4, 1'b0});
        step(5'b00010, 5'd0, 1'b0, 1'b1);
        chk("midrst_regrant", {grant2, sel2}, {5'b00010, 3'd1});

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step(5'($urandom), 5'($urandom), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 63) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
